instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Front-end stage directly upstream of instruction decode.
- Holds the PC and issues word fetches to the instruction memory port, one request outstanding at a time.
- Buffers returned words with their PCs and presents them on a decoupled output to decode.
- A redirect (flush) from the back end retargets the PC, empties the buffer and drops any in-flight response.

Parameters:
- RESET_PC, 32'h8000_0000, PC of the first fetch after reset.
- BUF_DEPTH, 2, entries in the output buffer; must be ≥1.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- fetched  decoupled.out  fetched_instr  {pc, raw} to decode; valid/ready handshake.
- mem_req_valid  output  1  fetch request.
- mem_req_ready  input  1  memory accepts request.
- mem_req_addr  output  32  word address; bits [1:0] always 0.
- mem_resp_valid  input  1  response present (single cycle, no backpressure).
- mem_resp_data  input  32  fetched word.
- mem_resp_fault  input  1  access fault for this response.
- flush  input  1  redirect request.
- flush_target  input  32  new PC; bits [1:0] ignored and treated as 0.

Behaviour:
- Reset (rst low, asynchronous): pc = RESET_PC, state = S_REQ, buffer empty, mem_req_valid = 0, fetched.valid = 0.
- Request accepted on mem_req_valid && mem_req_ready.
- Response arrives no earlier than the cycle after acceptance.
- Memory returns responses in order.
- FSM states:
  - S_REQ: mem_req_valid = (occupancy < BUF_DEPTH); mem_req_addr = pc. On acceptance: pc += 4 (wraps modulo 2^32), go to S_WAIT.
  - S_WAIT: mem_req_valid = 0. On mem_resp_valid: push {pc_of_req, raw} into the buffer, go to S_REQ. raw = mem_resp_fault ? 32'h0 : mem_resp_data. An all-zero raw has opcode[1:0] = 00, so decode produces INSTR_INVAL.
  - S_DISCARD: mem_req_valid = 0. On mem_resp_valid: drop the word, go to S_REQ.
- pc_of_req is a register captured at acceptance.
- Space reservation: a request is issued only when occupancy < BUF_DEPTH. A same-cycle pop does not count toward space. The push therefore can never overflow.
- Buffer output:
  - fetched.valid = buffer non-empty.
  - fetched.data = head entry.
  - Pop on fetched.valid && fetched.ready.
  - Push and pop may occur in the same cycle.
  - No combinational path from mem_resp_* to fetched.*: minimum latency is response cycle + 1.
- Flush (highest priority, registered effect):
  - pc <= {flush_target[31:2], 2'b00}; buffer cleared.
  - A pop in the same cycle is ignored; the cleared state wins.
  - Next state on flush:
    - S_REQ with acceptance in the same cycle → S_DISCARD.
    - S_REQ without acceptance → S_REQ.
    - S_WAIT without a response this cycle → S_DISCARD.
    - S_WAIT with a response this cycle → response dropped, S_REQ.
    - S_DISCARD with no response → stay S_DISCARD, new pc kept.
    - S_DISCARD with a response this cycle → S_REQ.
  - The first request after a flush uses the new pc.
- mem_req_valid, once asserted in S_REQ, stays high with a stable address until accepted or until a flush. A flush may withdraw it, and the next cycle presents the new address.
- Reset asserted mid-operation: immediate return to reset values. Any later stale response is ignored (state S_REQ, no request outstanding, mem_resp_valid ignored outside S_WAIT/S_DISCARD).
- mem_resp_valid in S_REQ is a protocol violation; an assertion flags it and the response is ignored.

Decomposition:
- types.sv: fetched_instr struct {addr pc; instr raw}, addr typedef (32-bit), FETCH_FAULT_WORD = 32'h0.
- Sub-module fetch_buffer: parameterised BUF_DEPTH FIFO of fetched_instr with push, pop, clear, count, and the same clk/rst.
- The FSM and PC stay in instr_fetch.

Test Plan:
1. Reset release, mem_req_ready = 1, 1-cycle response, fetched.ready = 1 → requests at 0x8000_0000, 0x8000_0004, 0x8000_0008; fetched outputs those PCs in order, each one cycle after its response.
2. fetched.ready = 0 for 10 cycles → exactly 2 words buffered, mem_req_valid held 0 afterwards. Release ready → both pop, then fetching resumes at 0x8000_0008.
3. flush with flush_target = 0x0000_1003 while in S_WAIT → the pending response (data 0xDEADBEEF) is dropped; next request addr = 0x0000_1000; the buffer was emptied the cycle after the flush.
4. flush in the same cycle as the response → no word delivered; next request at the target.
5. mem_resp_fault = 1 with data 0x00000013 → fetched.raw = 0x0, pc is that of the faulting request.
6. rst pulled low while in S_WAIT, response arrives during reset → after release, first request at RESET_PC, no word delivered from the stale response.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;

    // One buffered fetch result: the PC it was fetched from and the raw word.
    typedef struct packed {
        addr_t  pc;
        instr_t raw;
    } fetched_instr_t;

    // A faulting fetch is delivered as all-zero so decode flags it invalid.
    localparam instr_t FETCH_FAULT_WORD = 32'h0;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DISCARD
    } fetch_state_e;

    // Force an address onto a word boundary.
    function automatic addr_t align_word(input addr_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Decoupled valid/ready channel carrying fetched instructions to decode.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic           valid;
    logic           ready;
    fetched_instr_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/instr_fetch_buffer.sv
// Small FIFO of fetched instructions with synchronous clear.
module instr_fetch_buffer
    import instr_fetch_pkg::*;
#(
    parameter  int BUF_DEPTH = 2,
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetched_instr_t   push_data,
    input  logic             pop,
    input  logic             clear,
    output fetched_instr_t   head,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetched_instr_t   entries_q [BUF_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy update; clear wins over push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            entries_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = entries_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one word fetch at a time and buffers results for decode.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter addr_t RESET_PC  = 32'h8000_0000,
    parameter int    BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_if.master        fetched,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output addr_t                mem_req_addr,
    input  logic                 mem_resp_valid,
    input  instr_t               mem_resp_data,
    input  logic                 mem_resp_fault,
    input  logic                 flush,
    input  addr_t                flush_target
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e     state_q, state_d;
    addr_t            pc_q, pc_d;
    addr_t            req_pc_q, req_pc_d;
    logic             buf_push, buf_pop;
    fetched_instr_t   push_data, head;
    logic [CNT_W-1:0] count;

    instr_fetch_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (push_data),
        .pop       (buf_pop),
        .clear     (flush),
        .head      (head),
        .count     (count)
    );

    // Next-state, PC and request logic; a flush overrides the PC and turns
    // any request left in flight into one whose response is discarded.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        buf_push      = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = pc_q;
        case (state_q)
            S_REQ: begin
                // Space is reserved up front so the later push cannot overflow.
                mem_req_valid = rst && (count < CNT_W'(BUF_DEPTH));
                if (mem_req_valid && mem_req_ready) begin
                    pc_d     = pc_q + 32'd4;
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    buf_push = !flush;
                    state_d  = S_REQ;
                end
            end
            S_DISCARD: begin
                if (mem_resp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
        if (flush) begin
            pc_d = align_word(flush_target);
            if (state_d == S_WAIT) state_d = S_DISCARD;
        end
    end

    // State, PC and in-flight request PC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign push_data.pc  = req_pc_q;
    assign push_data.raw = mem_resp_fault ? FETCH_FAULT_WORD : mem_resp_data;

    // A pop coinciding with a flush is ignored; the buffer is cleared instead.
    assign buf_pop       = fetched.valid && fetched.ready && !flush;
    assign fetched.valid = (count != '0);
    assign fetched.data  = head;

    // A response with no request outstanding breaks the memory protocol.
    assert property (@(posedge clk) disable iff (!rst)
        !(mem_resp_valid && (state_q == S_REQ)));

endmodule
